// File: rtl/data_mem_param.sv
// data_mem_param: parametrised multi-cycle data memory that stalls the CPU via busy_wait.
// Define DMEM_STATS_EN to add saturating rd_count/wr_count completion counters.
module data_mem_param #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              busy_wait,
  output logic              req_error
`ifdef DMEM_STATS_EN
  ,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
`endif
);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, rdata_q, rdata_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic valid, fin, in_range;
  logic [IDX_W-1:0] idx;
  assign valid     = read ^ write;
  assign fin       = state_q == ACCESS && count_q == '0;
  assign in_range  = {1'b0, addr_q} < (ADDR_W+1)'(DEPTH);
  assign idx       = addr_q[IDX_W-1:0];
  assign busy_wait = (state_q == IDLE && valid) || state_q == ACCESS;
  assign req_error = state_q == IDLE && read && write;
  assign read_data = rdata_q;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = fin && !wr_q ? (in_range ? mem_q[idx] : '0) : rdata_q;
    if (state_q == IDLE && valid) begin
      state_d = ACCESS;
      count_d = CNT_W'(LATENCY - 1);
      wr_d    = write;
      addr_d  = address;
      data_d  = write_data;
    end else if (state_q == ACCESS) begin
      state_d = fin ? DONE : ACCESS;
      count_d = fin ? count_q : count_q - 1'b1;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end
  // out-of-range writes are dropped; the access still takes the full latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (fin && wr_q && in_range) begin
      mem_q[idx] <= data_q;
    end
  end
`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (fin && !wr_q && rd_count != 16'hFFFF) rd_count <= rd_count + 1'b1;
      if (fin && wr_q && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_data_mem_param.sv
// tb_data_mem_param: scoreboard bench for a default and a small LATENCY=1 data_mem_param instance.
module tb_data_mem_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd0 = 0, wr0 = 0, rd1 = 0, wr1 = 0;
  logic [7:0] addr0 = '0, wd0 = '0, rdata0;
  logic [3:0] addr1 = '0;
  logic [15:0] wd1 = '0, rdata1;
  logic busy0, busy1, err0, err1;
  logic [7:0] ref0 [256];
  logic [15:0] ref1 [10];
  logic [15:0] exp_q [$];
  logic [15:0] last_rd0;
  int n_cmp = 0, n_err = 0;
  int rdc0 = 0, wrc0 = 0;
`ifdef DMEM_STATS_EN
  logic [15:0] rdcnt0, wrcnt0, rdcnt1, wrcnt1;
`endif
  always #5 clk = ~clk;
  data_mem_param u0 (
    .clk(clk), .rst(rst), .read(rd0), .write(wr0), .address(addr0), .write_data(wd0),
    .read_data(rdata0), .busy_wait(busy0), .req_error(err0)
`ifdef DMEM_STATS_EN
    , .rd_count(rdcnt0), .wr_count(wrcnt0)
`endif
  );
  data_mem_param #(.DATA_W(16), .ADDR_W(4), .DEPTH(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .read(rd1), .write(wr1), .address(addr1), .write_data(wd1),
    .read_data(rdata1), .busy_wait(busy1), .req_error(err1)
`ifdef DMEM_STATS_EN
    , .rd_count(rdcnt1), .wr_count(wrcnt1)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic busy(input int inst);
    return inst != 0 ? busy1 : busy0;
  endfunction
  function automatic logic [15:0] rdata(input int inst);
    return inst != 0 ? rdata1 : {8'h00, rdata0};
  endfunction
  task automatic clear_models();
    foreach (ref0[i]) ref0[i] = '0;
    foreach (ref1[i]) ref1[i] = '0;
    exp_q.delete();
    last_rd0 = '0;
    rdc0 = 0;
    wrc0 = 0;
  endtask
  // drive one request, hold it through DONE, then check stall length, data and no retrigger
  task automatic op(input int inst, input bit rd, input bit wr, input logic [7:0] a, input logic [15:0] d);
    int stall;
    int lat;
    lat = inst != 0 ? 1 : 5;
    @(negedge clk);
    if (inst == 0) begin rd0 = rd; wr0 = wr; addr0 = a; wd0 = d[7:0]; end
    else begin rd1 = rd; wr1 = wr; addr1 = a[3:0]; wd1 = d; end
    if (rd) exp_q.push_back(inst != 0 ? (a < 10 ? ref1[a] : 16'h0000) : {8'h00, ref0[a]});
    #1 chk("busy_rise", busy(inst), 1);
    stall = 1;
    for (int i = 0; i < 50 && busy(inst); i++) begin
      @(posedge clk);
      #1;
      if (busy(inst)) stall++;
    end
    chk("stall_len", stall, lat + 1);
    if (wr) begin
      if (inst == 0) begin ref0[a] = d[7:0]; wrc0++; end
      else if (a < 10) ref1[a] = d;
    end
    if (rd) begin
      if (inst == 0) rdc0++;
      if (exp_q.size() == 0) chk("sb_empty", 1, 0);
      else begin
        if (inst == 0) last_rd0 = exp_q[0];
        chk("rdata", rdata(inst), exp_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (inst == 0) begin rd0 = 0; wr0 = 0; end
    else begin rd1 = 0; wr1 = 0; end
    #1 chk("no_retrigger", busy(inst), 0);
  endtask
  initial begin
    clear_models();
    #1;
    chk("rst_busy0", busy0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_rdata1", rdata1, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    op(0, 1, 0, 8'h10, 16'h0);
    op(0, 0, 1, 8'h10, 16'h00A5);
    op(0, 1, 0, 8'h10, 16'h0);
    op(0, 0, 1, 8'h11, 16'h005A);
    chk("rdata_hold", rdata0, last_rd0);
    op(0, 0, 1, 8'hFF, 16'h00C3);
    op(0, 1, 0, 8'hFF, 16'h0);
    op(0, 1, 0, 8'h11, 16'h0);
    // both requests in IDLE: flagged, no stall, nothing changes
    @(negedge clk);
    rd0 = 1; wr0 = 1; addr0 = 8'h11; wd0 = 8'h77;
    #1 chk("req_err", err0, 1);
    chk("req_err_busy", busy0, 0);
    repeat (2) @(posedge clk);
    #1 chk("req_err_hold", err0, 1);
    chk("req_err_busy2", busy0, 0);
    chk("req_err_rdata", rdata0, last_rd0);
    rd0 = 0; wr0 = 0;
    op(0, 1, 0, 8'h11, 16'h0);
    // reset during the third ACCESS cycle of a write
    @(negedge clk);
    wr0 = 1; addr0 = 8'h20; wd0 = 8'h3C;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    wr0 = 0;
    #1 chk("rst_mid_busy", busy0, 0);
    chk("rst_mid_rdata", rdata0, 0);
    clear_models();
    @(negedge clk);
    rst = 0;
    op(0, 1, 0, 8'h20, 16'h0);
    op(0, 1, 0, 8'h10, 16'h0);
    op(1, 0, 1, 8'd9, 16'hBEEF);
    op(1, 1, 0, 8'd9, 16'h0);
    op(1, 0, 1, 8'd12, 16'h1234);
    op(1, 1, 0, 8'd12, 16'h0);
    op(1, 1, 0, 8'd0, 16'h0);
`ifdef DMEM_STATS_EN
    chk("rd_count_run", rdcnt0, rdc0);
    chk("wr_count_run", wrcnt0, wrc0);
    @(negedge clk);
    rst = 1;
    #1 clear_models();
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) op(0, 0, 1, 8'(8'h40 + i), 16'(16'h10 + i));
    for (int i = 0; i < 2; i++) op(0, 1, 0, 8'(8'h40 + i), 16'h0);
    chk("wr_count", wrcnt0, 3);
    chk("rd_count", rdcnt0, 2);
    @(negedge clk);
    rst = 1;
    #1 chk("wr_count_rst", wrcnt0, 0);
    chk("rd_count_rst", rdcnt0, 0);
    @(negedge clk);
    rst = 0;
`endif
    if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/data_mem_param.md
Name: data_mem_param

Overview:
Parametrised, multi-cycle data memory that stalls the CPU through a busy_wait handshake.
- Successor to the fixed 256x8 data memory: data width, address width, depth and access latency are all configurable.
- Adds a real latency counter and a request-release cycle.
- Sits between the CPU load/store path and, later, a cache controller.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W
LATENCY, 5, clock edges from request acceptance to completion; must be >= 1

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
read  input  1  read request; held by CPU until busy_wait falls
write  input  1  write request; held by CPU until busy_wait falls
address  input  ADDR_W  word address
write_data  input  DATA_W  store data
read_data  output  DATA_W  load data, registered
busy_wait  output  1  CPU stall
req_error  output  1  read and write both asserted while IDLE

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, count=0, read_data=0, every memory word=0, busy_wait=0, req_error=0.
  - Asserting rst mid-access aborts the access; no memory word is written.
- Valid request is read XOR write.
- State machine IDLE / ACCESS / DONE:
  - IDLE, valid request present: latch op, address and write_data; count=LATENCY-1; go to ACCESS.
  - IDLE, both read and write high: no access; stay IDLE.
  - ACCESS, count!=0: count decrements; address/data/op changes on the inputs are ignored because the latched copies are used.
  - ACCESS, count==0:
    - write: mem[addr_q]<=data_q.
    - read: read_data<=mem[addr_q].
    - go to DONE.
  - DONE: exactly one cycle with busy_wait=0; request inputs are ignored, so a still-held request does not retrigger; return to IDLE.
- busy_wait is combinational: 1 when (IDLE and valid request) or ACCESS; 0 otherwise.
  - Rises in the same cycle the request is raised.
  - Falls immediately after edge E_LATENCY, where E0 is the accepting edge.
  - Total stall = LATENCY+1 cycles including the request cycle.
- req_error is combinational: 1 when IDLE and read and write are both high; busy_wait stays 0 in that case.
- Out-of-range address (address >= DEPTH): write is discarded; read returns 0. Timing is identical to an in-range access.
- read_data holds its last loaded value between reads; it is not changed by writes.
- Back-to-back accesses: a new request is first sampled in the IDLE cycle after DONE, giving a minimum 2-cycle gap between completion and the next acceptance.
- LATENCY=1: ACCESS lasts one edge; the operation completes on edge E1.

Optional Feature:
DMEM_STATS_EN
- Defined:
  - Adds output ports rd_count[15:0] and wr_count[15:0].
  - Each increments on the edge that completes a read or write, including out-of-range accesses.
  - Each saturates at 16'hFFFF.
  - Both are cleared by rst.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Write, defaults: write=1, address=8'h10, write_data=8'hA5 held until busy_wait=0 → busy_wait high for 6 cycles; mem[16]=8'hA5; one DONE cycle; no second write.
- Read back: read=1, address=8'h10 → after 6 stall cycles read_data=8'hA5; read_data unchanged by a following write to 8'h11.
- Simultaneous requests: read=1 and write=1 in IDLE → req_error=1, busy_wait=0, memory unchanged, read_data unchanged.
- Reset mid-write: write to 8'h20 with data 8'h3C, rst pulsed at cycle 3 of ACCESS → busy_wait=0 at once, mem[32]=0, state IDLE.
- Parametrised instance with DATA_W=16, ADDR_W=4, DEPTH=10, LATENCY=1:
  - write 16'hBEEF to address 9 → 2-cycle stall; readback gives 16'hBEEF.
  - read address 12 → 16'h0000.
- With DMEM_STATS_EN defined: 3 writes then 2 reads → wr_count=3, rd_count=2; rst clears both to 0.
